// File: rtl/occupancy_detector.sv
// occupancy_detector
// Turns raw PIR motion bits into a stable occupancy flag: 2-flop synchroniser per
// bit, tick-based debounce, then a hold timer that keeps the room occupied for
// HOLD_TICKS ticks after the last detection.
// Optional feature macro: OCC_FORCE_ON_EN adds a force_on input that overrides
// occupied/presence to 1 without disturbing the FSM or the hold timer.

`ifndef MOTION_SENSOR_DATA_WIDTH
`define MOTION_SENSOR_DATA_WIDTH 1
`endif

module occupancy_detector #(
   parameter int MOTION_W       = `MOTION_SENSOR_DATA_WIDTH,
   parameter int PRESCALE       = 1000,
   parameter int DEBOUNCE_TICKS = 3,
   parameter int HOLD_TICKS     = 300,
   parameter int CNT_W          = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [MOTION_W-1:0] motion_raw,
   input  logic                hold_clear,
`ifdef OCC_FORCE_ON_EN
   input  logic                force_on,
`endif
   output logic [MOTION_W-1:0] presence,
   output logic                occupied,
   output logic [CNT_W-1:0]    hold_remaining,
   output logic                vacated_pulse
);

   localparam int PS_W  = $clog2(PRESCALE);
   localparam int DEB_W = $clog2(DEBOUNCE_TICKS + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONFIRM,
      S_OCCUPIED,
      S_HOLD
   } state_t;

   logic [MOTION_W-1:0] w_sync;
   logic                w_detect;
   logic                w_tick;
   logic                w_occ_fsm;

   logic [PS_W-1:0]     r_presc;
   state_t              r_state;
   state_t              w_state_next;
   logic [DEB_W-1:0]    r_deb;
   logic [DEB_W-1:0]    w_deb_next;
   logic [CNT_W-1:0]    r_hold;
   logic [CNT_W-1:0]    w_hold_next;
   logic                r_pulse;
   logic                w_pulse_next;

   // Per-bit two-flop synchroniser for the asynchronous sensor inputs
   genvar gi;
   generate
      for (gi = 0; gi < MOTION_W; gi++) begin : g_sync
         logic r_meta;
         logic r_stable;

         // Shift the raw bit through two flops to resolve metastability
         always_ff @(posedge clk) begin
            if (rst) begin
               r_meta   <= 1'b0;
               r_stable <= 1'b0;
            end else begin
               r_meta   <= motion_raw[gi];
               r_stable <= r_meta;
            end
         end

         assign w_sync[gi] = r_stable;
      end
   endgenerate

   assign w_detect = |w_sync;

   // Free-running prescaler; only rst touches it so tick phase is independent of FSM events
   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc <= '0;
      end else if (r_presc == PS_W'(PRESCALE - 1)) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + PS_W'(1);
      end
   end

   assign w_tick = (r_presc == PS_W'(PRESCALE - 1));

   // State, counters and the registered vacancy strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_deb   <= '0;
         r_hold  <= '0;
         r_pulse <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_deb   <= w_deb_next;
         r_hold  <= w_hold_next;
         r_pulse <= w_pulse_next;
      end
   end

   // Next-state and counter updates; hold_clear overrides every other transition
   always_comb begin
      w_state_next = r_state;
      w_deb_next   = r_deb;
      w_hold_next  = r_hold;
      w_pulse_next = 1'b0;

      if (hold_clear) begin
         w_state_next = S_IDLE;
         w_deb_next   = '0;
         w_hold_next  = '0;
         w_pulse_next = (r_state == S_OCCUPIED) || (r_state == S_HOLD);
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_detect) begin
                  w_state_next = S_CONFIRM;
                  w_deb_next   = '0;
               end
            end

            S_CONFIRM: begin
               if (!w_detect) begin
                  w_state_next = S_IDLE;
                  w_deb_next   = '0;
               end else if (w_tick) begin
                  // The tick that completes the debounce promotes instead of counting,
                  // so deb never exceeds DEBOUNCE_TICKS-1
                  if (r_deb == DEB_W'(DEBOUNCE_TICKS - 1)) begin
                     w_state_next = S_OCCUPIED;
                     w_deb_next   = '0;
                     w_hold_next  = CNT_W'(HOLD_TICKS);
                  end else begin
                     w_deb_next   = r_deb + DEB_W'(1);
                  end
               end
            end

            S_OCCUPIED: begin
               w_hold_next = CNT_W'(HOLD_TICKS);
               if (!w_detect) begin
                  w_state_next = S_HOLD;
               end
            end

            S_HOLD: begin
               if (w_detect) begin
                  // Motion during hold re-occupies immediately with a fresh timer
                  w_state_next = S_OCCUPIED;
                  w_hold_next  = CNT_W'(HOLD_TICKS);
               end else if (w_tick) begin
                  if (r_hold != '0) begin
                     w_hold_next = r_hold - CNT_W'(1);
                  end
                  if (r_hold == CNT_W'(1)) begin
                     w_state_next = S_IDLE;
                     w_pulse_next = 1'b1;
                  end
               end
            end

            default: begin
               w_state_next = S_IDLE;
               w_deb_next   = '0;
               w_hold_next  = '0;
            end
         endcase
      end
   end

   assign w_occ_fsm = (r_state == S_OCCUPIED) || (r_state == S_HOLD);

`ifdef OCC_FORCE_ON_EN
   assign occupied = w_occ_fsm | force_on;
`else
   assign occupied = w_occ_fsm;
`endif

   assign presence       = {MOTION_W{occupied}};
   assign hold_remaining = w_occ_fsm ? r_hold : '0;
   assign vacated_pulse  = r_pulse;

endmodule

// File: tb/tb_occupancy_detector.sv
// tb_occupancy_detector
// Scenario tasks plus a randomized run, compared cycle by cycle against a
// behavioural occupancy model that works in ticks and plain integers.

`timescale 1ns/1ps

module tb_occupancy_detector;

   localparam int MW    = 1;
   localparam int P     = 4;
   localparam int DEB   = 2;
   localparam int HOLD  = 5;
   localparam int CNT_W = 16;
   localparam int VW    = 2 + MW + CNT_W;

   logic             clk;
   logic             rst;
   logic [MW-1:0]    motion_raw;
   logic             hold_clear;
   logic             force_on;
   logic [MW-1:0]    presence;
   logic             occupied;
   logic [CNT_W-1:0] hold_remaining;
   logic             vacated_pulse;

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model state
   bit m_s1, m_s2;      // motion seen through the two synchroniser stages
   int m_cycle;         // cycles since the prescaler was last cleared
   bit m_occ;           // room considered occupied
   bit m_pending;       // motion seen, waiting for enough ticks
   int m_ticks;         // debounce ticks collected so far
   bit m_gone;          // motion has ended and the hold timer is running
   int m_hold;          // ticks left before vacancy
   bit m_pulse;

   occupancy_detector #(
      .MOTION_W(MW), .PRESCALE(P), .DEBOUNCE_TICKS(DEB),
      .HOLD_TICKS(HOLD), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .motion_raw(motion_raw),
      .hold_clear(hold_clear),
`ifdef OCC_FORCE_ON_EN
      .force_on(force_on),
`endif
      .presence(presence),
      .occupied(occupied),
      .hold_remaining(hold_remaining),
      .vacated_pulse(vacated_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_update();
      bit det;
      bit tick;
      det  = m_s2;
      tick = (m_cycle % P) == (P - 1);
      if (rst) begin
         m_s1 = 0; m_s2 = 0; m_cycle = 0; m_occ = 0; m_pending = 0;
         m_ticks = 0; m_gone = 0; m_hold = 0; m_pulse = 0;
         return;
      end
      m_pulse = 0;
      if (hold_clear) begin
         m_pulse = m_occ;
         m_occ = 0; m_pending = 0; m_ticks = 0; m_hold = 0; m_gone = 0;
      end else if (m_occ) begin
         if (det) begin
            m_hold = HOLD; m_gone = 0;
         end else if (!m_gone) begin
            m_gone = 1;
         end else if (tick) begin
            m_hold = m_hold - 1;
            if (m_hold == 0) begin
               m_occ = 0; m_gone = 0; m_pulse = 1;
            end
         end
      end else if (m_pending) begin
         if (!det) begin
            m_pending = 0;
         end else if (tick) begin
            m_ticks = m_ticks + 1;
            if (m_ticks == DEB) begin
               m_occ = 1; m_pending = 0; m_hold = HOLD; m_gone = 0;
            end
         end
      end else if (det) begin
         m_pending = 1; m_ticks = 0;
      end
      m_s2 = m_s1;
      m_s1 = |motion_raw;
      m_cycle = m_cycle + 1;
   endtask

   function automatic logic [VW-1:0] exp_vec();
      bit occ_eff;
      int hr;
      occ_eff = m_occ;
`ifdef OCC_FORCE_ON_EN
      occ_eff = m_occ | force_on;
`endif
      hr = m_occ ? m_hold : 0;
      return {occ_eff, {MW{occ_eff}}, CNT_W'(hr), m_pulse};
   endfunction

   function automatic logic [VW-1:0] dut_vec();
      return {occupied, presence, hold_remaining, vacated_pulse};
   endfunction

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic test_reset();
      rst = 1; motion_raw = '1; hold_clear = 0; force_on = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (dut_vec() !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs cyc %0d got %h want 0", i, dut_vec());
         end
      end
      rst = 0; motion_raw = '0;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (dut_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL reset_idle cyc %0d got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      $display("test_reset done checks=%0d errors=%0d", n_checks, n_errors);
   endtask

   task automatic test_glitch();
      bit saw_occ = 0;
      for (int i = 0; i < 15; i++) begin
         motion_raw = (i < 3) ? '1 : '0;
         step();
         if (occupied) saw_occ = 1;
         n_checks++;
         if (dut_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL glitch_model cyc %0d got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      n_checks++;
      if (saw_occ !== 1'b0) begin
         n_errors++;
         $display("FAIL glitch_no_occupy got %0d want 0", saw_occ);
      end
      $display("test_glitch done checks=%0d errors=%0d", n_checks, n_errors);
   endtask

   task automatic test_occupancy();
      int n = 0;
      int pulses = 0;
      int last;
      int seq[$];
      motion_raw = '1;
      while (n < 20 && !occupied) begin
         step(); n++;
         n_checks++;
         if (dut_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL occ_rise_model cyc %0d got %h want %h", n, dut_vec(), exp_vec());
         end
      end
      n_checks++;
      if (!(occupied === 1'b1 && n <= 12)) begin
         n_errors++;
         $display("FAIL occ_latency got occ=%b after %0d cycles want occ=1 within 12", occupied, n);
      end
      n_checks++;
      if (hold_remaining !== CNT_W'(HOLD)) begin
         n_errors++;
         $display("FAIL occ_hold_load got %0d want %0d", hold_remaining, HOLD);
      end
      for (int i = 0; i < 3; i++) step();
      motion_raw = '0;
      last = hold_remaining;
      seq.push_back(last);
      for (int i = 0; i < 60; i++) begin
         step();
         if (vacated_pulse) pulses++;
         if (occupied && hold_remaining != last) begin
            last = hold_remaining;
            seq.push_back(last);
         end
         n_checks++;
         if (dut_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL occ_fall_model cyc %0d got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      n_checks++;
      if (seq.size() != HOLD) begin
         n_errors++;
         $display("FAIL hold_seq_len got %0d want %0d", seq.size(), HOLD);
      end else begin
         for (int k = 0; k < HOLD; k++) begin
            n_checks++;
            if (seq[k] != HOLD - k) begin
               n_errors++;
               $display("FAIL hold_seq[%0d] got %0d want %0d", k, seq[k], HOLD - k);
            end
         end
      end
      n_checks++;
      if (pulses != 1 || occupied !== 1'b0) begin
         n_errors++;
         $display("FAIL vacate got pulses=%0d occ=%b want pulses=1 occ=0", pulses, occupied);
      end
      $display("test_occupancy done checks=%0d errors=%0d", n_checks, n_errors);
   endtask

   task automatic test_return_in_hold();
      int pulses = 0;
      bit dropped = 0;
      motion_raw = '1;
      for (int i = 0; i < 20 && !occupied; i++) step();
      for (int i = 0; i < 2; i++) step();
      motion_raw = '0;
      for (int i = 0; i < 40 && !(occupied && hold_remaining == CNT_W'(2)); i++) begin
         step();
         n_checks++;
         if (dut_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL rih_model cyc %0d got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      n_checks++;
      if (!(occupied === 1'b1 && hold_remaining === CNT_W'(2))) begin
         n_errors++;
         $display("FAIL rih_reach2 got occ=%b hold=%0d want occ=1 hold=2", occupied, hold_remaining);
      end
      motion_raw = '1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (vacated_pulse) pulses++;
         if (!occupied) dropped = 1;
         n_checks++;
         if (dut_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL rih_return cyc %0d got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      n_checks++;
      if (hold_remaining !== CNT_W'(HOLD) || pulses != 0 || dropped) begin
         n_errors++;
         $display("FAIL rih_reload got hold=%0d pulses=%0d dropped=%0d want hold=%0d pulses=0 dropped=0",
                  hold_remaining, pulses, dropped, HOLD);
      end
      $display("test_return_in_hold done checks=%0d errors=%0d", n_checks, n_errors);
   endtask

   task automatic test_hold_clear();
      int n;
      motion_raw = '1;
      for (int i = 0; i < 20 && !occupied; i++) step();
      hold_clear = 1;
      step();
      n_checks++;
      if (occupied !== 1'b0 || vacated_pulse !== 1'b1) begin
         n_errors++;
         $display("FAIL clear_pulse got occ=%b pulse=%b want occ=0 pulse=1", occupied, vacated_pulse);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (dut_vec() !== exp_vec() || occupied !== 1'b0) begin
            n_errors++;
            $display("FAIL clear_held cyc %0d got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      hold_clear = 0;
      for (n = 1; n <= 20; n++) begin
         step();
         n_checks++;
         if (dut_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL clear_redeb cyc %0d got %h want %h", n, dut_vec(), exp_vec());
         end
         if (occupied) break;
      end
      n_checks++;
      if (!(occupied === 1'b1 && n >= P + 2 && n <= 2 * P + 1)) begin
         n_errors++;
         $display("FAIL clear_redeb_latency got occ=%b n=%0d want occ=1 n in [%0d,%0d]",
                  occupied, n, P + 2, 2 * P + 1);
      end
      $display("test_hold_clear done checks=%0d errors=%0d", n_checks, n_errors);
   endtask

   task automatic test_random();
      bit level = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 11) == 0) level = ~level;
         motion_raw = level ? '1 : '0;
         if ($urandom_range(0, 19) == 0) motion_raw = ~motion_raw;
         hold_clear = ($urandom_range(0, 99) == 0);
         rst        = ($urandom_range(0, 399) == 0);
         step();
         n_checks++;
         if (dut_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL random cyc %0d got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      rst = 0; hold_clear = 0; motion_raw = '0;
      $display("test_random done checks=%0d errors=%0d", n_checks, n_errors);
   endtask

`ifdef OCC_FORCE_ON_EN
   task automatic test_force_on();
      rst = 1; motion_raw = '0; hold_clear = 0; force_on = 0;
      step();
      rst = 0;
      step();
      force_on = 1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_checks++;
         if (occupied !== 1'b1 || presence !== '1 || hold_remaining !== '0 || dut_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL force_on cyc %0d got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      force_on = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if (vacated_pulse !== 1'b0 || dut_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL force_release cyc %0d got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      $display("test_force_on done checks=%0d errors=%0d", n_checks, n_errors);
   endtask
`endif

   initial begin
      test_reset();
      test_glitch();
      test_occupancy();
      test_return_in_hold();
      test_hold_clear();
      test_random();
`ifdef OCC_FORCE_ON_EN
      test_force_on();
`endif
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
